// File: rtl/sha256_round_ctrl.sv
// ----------------------------------------------------------------------------
// sha256_round_ctrl
//
// Round sequencer for one SHA-256 compression datapath and its
// synchronous-read round-constant memory (one cycle read latency).
// A job walks IDLE -> PRIME -> ROUND x NUM_ROUNDS -> FINAL -> DONE -> IDLE.
// The K-memory address is driven one cycle ahead of each round, so the
// constant for round r is present on Kt exactly while round == r.
//
// Optional feature (macro SHA256_ROUND_CTRL_SHA256D_EN):
//   defined   - every job runs two passes (sha256d); FINAL of pass 0 loops
//               back to PRIME with pass set to 1.
//   undefined - single pass only; pass stays 0.
//
// Ports:
//   clk         in   core clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   job request, only sampled in IDLE
//   halt        in   synchronous abort, back to IDLE next cycle
//   busy        out  high in every state except IDLE
//   k_addr      out  registered address to the K memory
//   round       out  index of the round currently executing
//   load_init   out  datapath loads IV/midstate into a..h
//   round_en    out  datapath executes one round with the Kt of this cycle
//   w_from_msg  out  round_en and round < MSG_WORDS
//   final_add   out  datapath adds a..h into H
//   pass        out  0 = first hash pass, 1 = second pass
//   done        out  one-cycle pulse, digest valid in datapath
// ----------------------------------------------------------------------------
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS = 64,
    parameter int MSG_WORDS  = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  halt,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] k_addr,
    output logic [ADDR_WIDTH-1:0] round,
    output logic                  load_init,
    output logic                  round_en,
    output logic                  w_from_msg,
    output logic                  final_add,
    output logic                  pass,
    output logic                  done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ROUND = ADDR_WIDTH'(NUM_ROUNDS - 1);
    // One bit wider than round so MSG_WORDS == 2**ADDR_WIDTH still compares.
    localparam logic [ADDR_WIDTH:0]   MSG_LIMIT  = (ADDR_WIDTH + 1)'(MSG_WORDS);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_k_addr;
    logic [ADDR_WIDTH-1:0] r_round;
    logic                  r_pass;
    logic                  r_busy;
    logic                  r_load_init;
    logic                  r_round_en;
    logic                  r_w_from_msg;
    logic                  r_final_add;
    logic                  r_done;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_k_addr_nxt;
    logic [ADDR_WIDTH-1:0] w_round_nxt;
    logic                  w_pass_nxt;

    // Next-state, next-address and pass bookkeeping; halt overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_k_addr_nxt = r_k_addr;
        w_round_nxt  = r_round;
        w_pass_nxt   = r_pass;
        if (halt) begin
            w_state_nxt  = ST_IDLE;
            w_k_addr_nxt = '0;
            w_round_nxt  = '0;
            w_pass_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt  = ST_PRIME;
                        w_k_addr_nxt = '0;
                        w_round_nxt  = '0;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                    end
                end
                ST_PRIME: begin
                    // K[0] is being read now; start fetching K[1].
                    w_state_nxt  = ST_ROUND;
                    w_k_addr_nxt = ADDR_WIDTH'(1);
                end
                ST_ROUND: begin
                    if (r_round == LAST_ROUND) begin
                        w_state_nxt  = ST_FINAL;
                        w_k_addr_nxt = '0;
                        w_round_nxt  = '0;
                    end else begin
                        // Address runs two ahead of the registered round so
                        // the memory output lines up with the next round.
                        w_state_nxt  = ST_ROUND;
                        w_round_nxt  = r_round + ADDR_WIDTH'(1);
                        w_k_addr_nxt = r_round + ADDR_WIDTH'(2);
                    end
                end
                ST_FINAL: begin
`ifdef SHA256_ROUND_CTRL_SHA256D_EN
                    if (!r_pass) begin
                        w_state_nxt  = ST_PRIME;
                        w_pass_nxt   = 1'b1;
                        w_k_addr_nxt = '0;
                        w_round_nxt  = '0;
                    end else begin
                        w_state_nxt  = ST_DONE;
                    end
`else
                    w_state_nxt = ST_DONE;
`endif
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                    w_pass_nxt  = 1'b0;
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_k_addr_nxt = '0;
                    w_round_nxt  = '0;
                    w_pass_nxt   = 1'b0;
                end
            endcase
        end
    end

    // State, address, round and pass registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_k_addr <= '0;
            r_round  <= '0;
            r_pass   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_k_addr <= w_k_addr_nxt;
            r_round  <= w_round_nxt;
            r_pass   <= w_pass_nxt;
        end
    end

    // Strobes registered from the next state so they match the state they
    // describe in the same cycle, with no input-to-output path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy       <= 1'b0;
            r_load_init  <= 1'b0;
            r_round_en   <= 1'b0;
            r_w_from_msg <= 1'b0;
            r_final_add  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_load_init  <= (w_state_nxt == ST_PRIME);
            r_round_en   <= (w_state_nxt == ST_ROUND);
            r_w_from_msg <= (w_state_nxt == ST_ROUND) && ({1'b0, w_round_nxt} < MSG_LIMIT);
            r_final_add  <= (w_state_nxt == ST_FINAL);
            r_done       <= (w_state_nxt == ST_DONE);
        end
    end

    assign busy       = r_busy;
    assign k_addr     = r_k_addr;
    assign round      = r_round;
    assign load_init  = r_load_init;
    assign round_en   = r_round_en;
    assign w_from_msg = r_w_from_msg;
    assign final_add  = r_final_add;
    assign pass       = r_pass;
    assign done       = r_done;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sha256_round_ctrl
//
// Directed bench for sha256_round_ctrl (default parameters). Cycle n is the
// clock period following rising edge n, where edge 0 samples start. Outputs
// are sampled 1 time unit after each rising edge. A one-cycle-latency K
// memory model feeds Kt so the address prefetch can be checked end to end.
// ----------------------------------------------------------------------------
module tb_sha256_round_ctrl;

`ifdef SHA256_ROUND_CTRL_SHA256D_EN
    localparam int DONE_CYC = 133;
`else
    localparam int DONE_CYC = 67;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        halt;
    logic        busy;
    logic [5:0]  k_addr;
    logic [5:0]  round;
    logic        load_init;
    logic        round_en;
    logic        w_from_msg;
    logic        final_add;
    logic        pass;
    logic        done;
    logic [31:0] kt;

    int checks = 0;
    int errors = 0;

    sha256_round_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .halt       (halt),
        .busy       (busy),
        .k_addr     (k_addr),
        .round      (round),
        .load_init  (load_init),
        .round_en   (round_en),
        .w_from_msg (w_from_msg),
        .final_add  (final_add),
        .pass       (pass),
        .done       (done)
    );

    always #5 clk = ~clk;

    // K memory model: real constants at the two ends, distinct filler elsewhere.
    function automatic logic [31:0] kmem(input logic [5:0] a);
        case (a)
            6'd0:    return 32'h428a2f98;
            6'd63:   return 32'hc67178f2;
            default: return {26'h2a5a5a5, a};
        endcase
    endfunction

    always @(posedge clk) kt <= kmem(k_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; halt = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            errors++; $display("FAIL reset_hold busy=%b done=%b pass=%b exp 0", busy, done, pass);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || load_init !== 1'b0 || round_en !== 1'b0) begin
                errors++; $display("FAIL reset_idle c=%0d busy=%b done=%b load=%b ren=%b exp 0", c, busy, done, load_init, round_en);
            end
            checks++;
            if (k_addr !== 6'd0 || round !== 6'd0) begin
                errors++; $display("FAIL reset_addr c=%0d k_addr=%0d round=%0d exp 0", c, k_addr, round);
            end
        end
    endtask

    // Single-pass job; with repulse, start is re-asserted in cycles 5 and 40.
    task automatic test_single_pass(input bit repulse);
        int dones;
        dones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 75; c++) begin
            start = repulse && (c == 5 || c == 40);
            if (done === 1'b1) dones++;
            checks++;
            if (busy !== (c <= 67)) begin
                errors++; $display("FAIL sp_busy c=%0d got %b exp %b", c, busy, (c <= 67));
            end
            checks++;
            if (load_init !== (c == 1)) begin
                errors++; $display("FAIL sp_load_init c=%0d got %b exp %b", c, load_init, (c == 1));
            end
            checks++;
            if (round_en !== (c >= 2 && c <= 65)) begin
                errors++; $display("FAIL sp_round_en c=%0d got %b exp %b", c, round_en, (c >= 2 && c <= 65));
            end
            checks++;
            if (w_from_msg !== (c >= 2 && c <= 17)) begin
                errors++; $display("FAIL sp_w_from_msg c=%0d got %b exp %b", c, w_from_msg, (c >= 2 && c <= 17));
            end
            checks++;
            if (final_add !== (c == 66)) begin
                errors++; $display("FAIL sp_final_add c=%0d got %b exp %b", c, final_add, (c == 66));
            end
            checks++;
            if (done !== (c == 67)) begin
                errors++; $display("FAIL sp_done c=%0d got %b exp %b", c, done, (c == 67));
            end
            checks++;
            if (pass !== 1'b0) begin
                errors++; $display("FAIL sp_pass c=%0d got %b exp 0", c, pass);
            end
            if (c >= 2 && c <= 65) begin
                checks++;
                if (round !== 6'(c - 2)) begin
                    errors++; $display("FAIL sp_round c=%0d got %0d exp %0d", c, round, c - 2);
                end
                checks++;
                if (k_addr !== 6'(c - 1)) begin
                    errors++; $display("FAIL sp_k_addr c=%0d got %0d exp %0d", c, k_addr, 6'(c - 1));
                end
                checks++;
                if (kt !== kmem(6'(c - 2))) begin
                    errors++; $display("FAIL sp_kt c=%0d got %h exp %h", c, kt, kmem(6'(c - 2)));
                end
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (dones != 1) begin
            errors++; $display("FAIL sp_done_count got %0d exp 1", dones);
        end
    endtask

    task automatic test_halt();
        int lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 30; c++) tick();
        checks++;
        if (round !== 6'd28 || round_en !== 1'b1) begin
            errors++; $display("FAIL halt_pre round=%0d ren=%b exp 28 1", round, round_en);
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (busy !== 1'b0 || round !== 6'd0 || k_addr !== 6'd0 || done !== 1'b0) begin
            errors++; $display("FAIL halt_idle busy=%b round=%0d k_addr=%0d done=%b exp 0", busy, round, k_addr, done);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL halt_quiet c=%0d busy=%b done=%b exp 0", c, busy, done);
            end
        end
        // halt and start together in IDLE: stay idle
        halt = 1'b1; start = 1'b1;
        tick();
        halt = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || load_init !== 1'b0) begin
            errors++; $display("FAIL halt_start busy=%b load=%b exp 0", busy, load_init);
        end
        tick();
        // fresh job after abort
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 300 && lat == 0; c++) begin
            if (done === 1'b1) lat = c;
            else tick();
        end
        checks++;
        if (lat != DONE_CYC) begin
            errors++; $display("FAIL halt_restart_latency got %0d exp %0d", lat, DONE_CYC);
        end
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        tick();
        for (int c = 1; c < DONE_CYC; c++) tick();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL b2b_done got %b exp 1", done);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle busy got %b exp 0", busy);
        end
        tick();
        checks++;
        if (load_init !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_restart load=%b busy=%b exp 1 1", load_init, busy);
        end
        start = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
    endtask

    task automatic test_reset_midjob();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || round !== 6'd0 || k_addr !== 6'd0 || round_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid busy=%b round=%0d k_addr=%0d ren=%b exp 0", busy, round, k_addr, round_en);
        end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 80; c++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rst_mid_quiet c=%0d done=%b busy=%b exp 0", c, done, busy);
            end
        end
    endtask

`ifdef SHA256_ROUND_CTRL_SHA256D_EN
    task automatic test_sha256d();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 140; c++) begin
            checks++;
            if (load_init !== (c == 1 || c == 67)) begin
                errors++; $display("FAIL dd_load_init c=%0d got %b", c, load_init);
            end
            checks++;
            if (pass !== (c >= 67 && c <= 133)) begin
                errors++; $display("FAIL dd_pass c=%0d got %b", c, pass);
            end
            checks++;
            if (final_add !== (c == 66 || c == 132)) begin
                errors++; $display("FAIL dd_final_add c=%0d got %b", c, final_add);
            end
            checks++;
            if (done !== (c == 133)) begin
                errors++; $display("FAIL dd_done c=%0d got %b", c, done);
            end
            checks++;
            if (round_en !== ((c >= 2 && c <= 65) || (c >= 68 && c <= 131))) begin
                errors++; $display("FAIL dd_round_en c=%0d got %b", c, round_en);
            end
            tick();
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0; start = 1'b0; halt = 1'b0;
        test_reset();
`ifdef SHA256_ROUND_CTRL_SHA256D_EN
        test_sha256d();
`else
        test_single_pass(1'b0);
        test_single_pass(1'b1);
`endif
        test_halt();
        test_back_to_back();
        test_reset_midjob();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
